fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side consumer for the asynchronous FIFO. It lives entirely in the read clock domain and drains the FIFO's read port (`empty`, `rd_en`, `rd_data`). It re-presents the words as a valid/ready stream for downstream logic. A 2-entry output buffer with credit-based prefetch gives 1 word/cycle throughput despite the FIFO's 1-cycle read latency, and never drops or duplicates a word.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO `WIDTH`.
- `CNT_W`, 16, width of the delivered-beat counter.

- `rd_clk`  in  1  read-domain clock; same clock as the FIFO read port.
- `rd_rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits new FIFO reads; already-issued reads still complete.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rd_en`  out  1  FIFO `rd_en`; combinational.
- `fifo_rd_data`  in  WIDTH  FIFO `rd_data`; valid in the cycle after `fifo_rd_en` is sampled.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  WIDTH  output word, head of the buffer.
- `level`  out  2  stored words plus in-flight reads, range 0..2.
- `beat_count`  out  CNT_W  count of completed `m_valid && m_ready` handshakes; wraps modulo 2^CNT_W.

## Operation
- State:
  - `inflight` flag: a read was issued last cycle.
  - `stored` count, 0..2.
  - 2 data registers, used as head/tail.
- `pop = m_valid && m_ready`.
- `fifo_rd_en = enable && !fifo_empty && (stored + inflight - pop) < 2`.
  - A pop in the same cycle frees a credit, so steady state is `stored=1`, `inflight=1`, with one issue per cycle.
- Capture: when `inflight` is 1, `fifo_rd_data` is written into the buffer at the next edge.
  - Capture happens even if `enable` has dropped.
  - The buffer never overflows, because the credit rule guarantees room.
- Buffer update:
  - Capture with no pop: `stored`+1.
  - Pop with no capture: `stored`−1.
  - Capture and pop together: `stored` is unchanged; the head advances and the new word goes to the tail.
- `m_valid = (stored != 0)`.
  - `m_data` and `m_valid` hold stable while `m_valid && !m_ready`.
- `level = stored + inflight`, registered.
- `beat_count` increments by 1 on each pop and wraps from all-ones to 0.
- FIFO empty: no issue happens. Words already buffered and in flight still drain.
- Reset mid-operation:
  - All state clears, including any in-flight read.
  - Any word already popped from the FIFO is discarded.
  - Upstream resets the FIFO and this block together, so no partial stream survives.

## Timing
- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `level` 0, `beat_count` 0.
  - While `rd_rst` is high, `fifo_rd_en` is forced to 0.
- Latency from `fifo_rd_en` sampled at edge E0 to the word captured: edge E1, with `m_valid` high after E1.
  - Minimum `fifo_empty` falling → `m_valid` is 2 edges.
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- Backpressure: with `m_ready` low, at most 2 words are taken from the FIFO. After that `fifo_rd_en` stays 0 until a pop.
- `fifo_rd_en` depends combinationally on `m_ready`, `fifo_empty`, `enable` and registered state only. There is no path from `fifo_rd_data` to `fifo_rd_en`.
- Ordering: output words appear in exact FIFO read order.

## Structure
- Shared header/package holds:
  - `BUF_DEPTH = 2`
  - `LEVEL_W = 2`
  - the FIFO read-latency constant `RD_LAT = 1`, shared with the FIFO and its bench.
- One sub-module: `fifo_rd_skid`, the 2-entry buffer.
  - Inputs: push, data, pop.
  - Outputs: valid, data, count.
- Top level holds the credit/issue logic, the `inflight` flag and `beat_count`.

## Test plan
- **Reset:** assert `rd_rst` for 3 cycles with the FIFO holding 5 words.
  - Required: all outputs 0.
  - Required: `fifo_rd_en` stays 0 during reset.
  - Required: `fifo_rd_en` rises on the first edge after release.
- **Streaming:** FIFO preloaded with 0x01..0x10 (16 words), `m_ready=1`, `enable=1`.
  - Required: 16 consecutive `m_valid` cycles carrying 0x01..0x10 in order.
  - Required: `beat_count` = 16 and `level` = 0 at the end.
- **Backpressure:** 8 words in the FIFO, `m_ready=0` for 10 cycles, then 1.
  - Required: exactly 2 `fifo_rd_en` pulses.
  - Required: `level` = 2.
  - Required: `m_data` holds the first word stable.
  - Required: after release, all 8 words arrive in order with no gap beyond the initial one.
- **Empty/underflow:** FIFO holds 1 word, `m_ready=1`.
  - Required: one read and one beat.
  - Required: `fifo_rd_en` never asserts while `fifo_empty`=1.
  - Required: `m_valid` drops after 1 beat.
- **Enable drop:** drop `enable` while `inflight`=1.
  - Required: the in-flight word is still delivered.
  - Required: no further `fifo_rd_en` until `enable` returns.
- **Random mix:** 200 words written from a fast write clock (period 5), read with a random `m_ready` (50%).
  - Required: scoreboard shows an exact match.
  - Required: `beat_count` = 200.
  - Required: `level` never exceeds 2.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the FIFO read-side stream consumer.
package fifo_rd_stream_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned LEVEL_W   = 2;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned OCC_W     = LEVEL_W + 1;

  typedef enum logic [LEVEL_W-1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_cnt_e;

  // Words stored or in flight once this cycle's pop retires.
  function automatic logic [OCC_W-1:0] committed_words(
    input logic [LEVEL_W-1:0] stored,
    input logic               inflight,
    input logic               pop
  );
    return {1'b0, stored} + OCC_W'(inflight) - OCC_W'(pop);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail output buffer; the head is always presented on data.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [LEVEL_W-1:0] count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  buf_cnt_e         cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case (cnt_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d = push_data;
          cnt_d  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        // Simultaneous push and pop replaces the head in place.
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d = push_data;
          cnt_d  = BUF_FULL;
        end else if (pop) begin
          cnt_d  = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            cnt_d = BUF_ONE;
          end
        end
      end
      default: cnt_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= BUF_EMPTY;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid = (cnt_q != BUF_EMPTY);
  assign data  = head_q;
  assign count = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream with credit-based prefetch.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               enable,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [WIDTH-1:0]   fifo_rd_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic [1:0]         level,
  output logic [CNT_W-1:0]   beat_count
);

  logic               skid_valid;
  logic [LEVEL_W-1:0] stored;
  logic               pop;
  logic [OCC_W-1:0]   committed;
  logic               rd_en;

  logic               inflight_q, inflight_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   beat_q, beat_d;

  assign pop = skid_valid && m_ready;

  // A pop this cycle frees a slot, so a read may be issued against it immediately.
  always_comb begin
    committed  = committed_words(stored, inflight_q, pop);
    rd_en      = !rd_rst && enable && !fifo_empty && (committed < OCC_W'(BUF_DEPTH));
    inflight_d = rd_en;
    level_d    = LEVEL_W'(committed + OCC_W'(rd_en));
    beat_d     = beat_q + CNT_W'(pop);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
      level_q    <= '0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      level_q    <= level_d;
      beat_q     <= beat_d;
    end
  end

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .valid     (skid_valid),
    .data      (m_data),
    .count     (stored)
  );

  assign fifo_rd_en = rd_en;
  assign m_valid    = skid_valid;
  assign level      = level_q;
  assign beat_count = beat_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: queue-based FIFO model and in-order scoreboard around fifo_rd_stream.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;

  logic             rd_clk = 1'b0;
  logic             wr_clk = 1'b0;
  logic             rd_rst = 1'b1;
  logic             enable = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       level;
  logic [CNT_W-1:0] beat_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_beats = 0;
  int unsigned rd_pulses = 0;
  bit          wr_done = 0;
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  fifo_rd_stream #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .beat_count   (beat_count)
  );

  always #5 rd_clk = ~rd_clk;
  always begin
    #2 wr_clk = 1'b1;
    #3 wr_clk = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    exp_beats++;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned c = 0;
    while ((exp_q.size() != 0 || m_valid) && c < budget) begin
      cyc(1);
      c++;
    end
    check(tag, c < budget, 1);
  endtask

  // FIFO read port: one-cycle read latency, registered empty flag.
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      rd_pulses++;
      check("rd_underflow", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge rd_clk) begin
    check("level_max", level <= 2'd2, 1);
    check("rd_en_gate", fifo_rd_en && (fifo_empty || rd_rst), 0);
    if (!rd_rst && m_valid && m_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_data", m_data, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with 5 words waiting in the FIFO
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) load(WIDTH'(8'hA0 + i));
    repeat (3) begin
      @(negedge rd_clk);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_level", level, 0);
      check("rst_beats", beat_count, 0);
    end
    @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    @(negedge rd_clk);
    check("rel_rd_en", fifo_rd_en, 1);
    drain("rst_drain", 50);
    @(negedge rd_clk);
    check("rst_beat_total", beat_count, exp_beats);

    // Streaming 0x01..0x10
    cyc(1);
    for (int i = 0; i < 16; i++) load(WIDTH'(i + 1));
    begin
      int unsigned c = 0;
      while (!m_valid && c < 10) begin cyc(1); c++; end
      check("stream_start", c < 10, 1);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge rd_clk);
      check("stream_valid", m_valid, 1);
      check("stream_data", m_data, i + 1);
    end
    drain("stream_drain", 50);
    @(negedge rd_clk);
    check("stream_beats", beat_count, exp_beats);
    check("stream_level", level, 0);

    // Backpressure: 8 words, m_ready low for 10 cycles
    cyc(1);
    m_ready   = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) load(WIDTH'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (i >= 4) check("bp_hold", m_data, 8'h20);
    end
    check("bp_pulses", rd_pulses, 2);
    check("bp_level", level, 2);
    check("bp_valid", m_valid, 1);
    @(posedge rd_clk);
    #1 m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      check("bp_run", m_valid && m_ready, 1);
      check("bp_order", m_data, 8'h20 + i);
    end
    drain("bp_drain", 50);
    @(negedge rd_clk);
    check("bp_beats", beat_count, exp_beats);

    // Single word then empty
    cyc(1);
    rd_pulses = 0;
    load(8'h55);
    repeat (8) @(negedge rd_clk);
    check("uf_pulses", rd_pulses, 1);
    check("uf_valid", m_valid, 0);
    check("uf_beats", beat_count, exp_beats);

    // Enable dropped right after one read issues
    cyc(1);
    enable    = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 4; i++) load(WIDTH'(8'h60 + i));
    cyc(3);
    check("en_off_pulses", rd_pulses, 0);
    enable = 1'b1;
    cyc(1);
    enable = 1'b0;
    repeat (6) @(negedge rd_clk);
    check("en_pulses", rd_pulses, 1);
    check("en_beats", beat_count, exp_beats - 3);
    check("en_hold_rd_en", fifo_rd_en, 0);
    cyc(1);
    enable = 1'b1;
    drain("en_drain", 50);
    @(negedge rd_clk);
    check("en_pulses_total", rd_pulses, 4);
    check("en_beats_total", beat_count, exp_beats);

    // Reset mid-operation with words buffered and in flight
    cyc(1);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(WIDTH'(8'h70 + i));
    cyc(3);
    rd_rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    exp_beats = 0;
    cyc(1);
    @(negedge rd_clk);
    check("mr_valid", m_valid, 0);
    check("mr_data", m_data, 0);
    check("mr_level", level, 0);
    check("mr_beats", beat_count, 0);
    cyc(1);
    rd_rst  = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(negedge rd_clk);
    check("mr_no_survivor", m_valid, 0);
    check("mr_level_after", level, 0);

    // Random mix: 200 words from the fast write clock, random m_ready
    cyc(1);
    fork
      begin
        int unsigned n = 0;
        while (n < 200) begin
          @(posedge wr_clk);
          if ($urandom_range(0, 2) != 0) begin
            load(WIDTH'($urandom_range(0, 255)));
            n++;
          end
        end
        wr_done = 1;
      end
      begin
        int unsigned c = 0;
        while ((!wr_done || exp_q.size() != 0) && c < 20000) begin
          @(posedge rd_clk);
          #1 m_ready = 1'($urandom_range(0, 1));
          c++;
        end
        check("rnd_timeout", c < 20000, 1);
      end
    join
    m_ready = 1'b1;
    @(negedge rd_clk);
    check("rnd_beats", beat_count, 200);
    check("rnd_sb_empty", exp_q.size(), 0);
    drain("rnd_drain", 20);
    @(negedge rd_clk);
    check("rnd_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
